// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch stage,
// data/valid back from memory.
interface fetch_unit_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Cirno fetch stage: holds the PC, fetches 9-bit instructions, pulses the
// decoder once per instruction and waits for control to resolve the next PC.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_restart,
    fetch_unit_if.master     imem,
    output logic [8:0]       o_inst,
    output logic [PC_W-1:0]  o_inst_pc,
    output logic             o_decoder_en,
    input  logic             i_resolve,
    input  logic             i_take_abs,
    input  logic [PC_W-1:0]  i_abs_target,
    input  logic             i_take_rel,
    input  logic [5:0]       i_rel_off,
    input  logic             i_done,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [PC_W-1:0]  w_rel_ext;
    logic [8:0]       r_inst;
    logic [PC_W-1:0]  r_inst_pc;
    logic [CNT_W-1:0] r_retired;
    logic             w_capture;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_capture    = 1'b0;
        w_rel_ext    = {{(PC_W-6){i_rel_off[5]}}, i_rel_off};

        if (i_restart) begin
            w_state_next = S_IDLE;
            w_pc_next    = RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) w_state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        w_capture    = 1'b1;
                        w_state_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    // Branch targets are relative to the issued instruction, not the live PC.
                    if (i_resolve) begin
                        if (i_done) begin
                            w_state_next = S_HALT;
                        end else begin
                            w_state_next = S_FETCH;
                            if (i_take_abs)      w_pc_next = i_abs_target;
                            else if (i_take_rel) w_pc_next = r_inst_pc + w_rel_ext;
                            else                 w_pc_next = r_inst_pc + PC_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    w_state_next = S_HALT;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= RESET_PC;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_capture) begin
                r_inst    <= imem.imem_rdata;
                r_inst_pc <= r_pc;
            end
            if (i_restart)               r_retired <= '0;
            else if (r_state == S_ISSUE) r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Every output is a register or a decode of the state register.
    assign imem.imem_req  = (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;
    assign o_decoder_en   = (r_state == S_ISSUE);
    assign o_halted       = (r_state == S_HALT);
    assign o_inst         = r_inst;
    assign o_inst_pc      = r_inst_pc;
    assign o_retired      = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized fetch/resolve
// traffic checked against a transaction-level PC model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        restart;
    logic [8:0]  inst;
    logic [7:0]  inst_pc;
    logic        decoder_en;
    logic        resolve;
    logic        take_abs;
    logic [7:0]  abs_target;
    logic        take_rel;
    logic [5:0]  rel_off;
    logic        done;
    logic        halted;
    logic [15:0] retired;

    fetch_unit_if #(.PC_W(8)) imem_bus ();

    fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_restart    (restart),
        .imem         (imem_bus),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc),
        .o_decoder_en (decoder_en),
        .i_resolve    (resolve),
        .i_take_abs   (take_abs),
        .i_abs_target (abs_target),
        .i_take_rel   (take_rel),
        .i_rel_off    (rel_off),
        .i_done       (done),
        .o_halted     (halted),
        .o_retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] mem [256];
    int         m_pc;
    int         m_retired;
    int         m_inst_pc;
    logic [8:0] m_inst;
    int         n_txn = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first FETCH cycle; leaves in the first WAIT cycle.
    task automatic fetch_one(input int lat, input bit early_resolve);
        check_val("fetch_req", 32'(imem_bus.imem_req), 32'd1);
        check_val("fetch_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
        for (int i = 0; i < lat; i++) begin
            tick();
            check_val("hold_req", 32'(imem_bus.imem_req), 32'd1);
            check_val("hold_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
            check_val("hold_no_dec", 32'(decoder_en), 32'd0);
        end
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = mem[m_pc];
        tick();
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = 9'($urandom);
        m_inst    = mem[m_pc];
        m_inst_pc = m_pc;
        check_val("issue_dec", 32'(decoder_en), 32'd1);
        check_val("issue_inst", 32'(inst), 32'(m_inst));
        check_val("issue_inst_pc", 32'(inst_pc), 32'(m_inst_pc));
        check_val("issue_no_req", 32'(imem_bus.imem_req), 32'd0);
        if (early_resolve) begin
            resolve    = 1'b1;
            done       = 1'($urandom);
            take_abs   = 1'($urandom);
            take_rel   = 1'($urandom);
            abs_target = 8'($urandom);
            rel_off    = 6'($urandom);
        end
        tick();
        resolve = 1'b0;
        done    = 1'b0;
        m_retired++;
        check_val("wait_dec_low", 32'(decoder_en), 32'd0);
        check_val("wait_retired", 32'(retired), 32'(m_retired & 16'hFFFF));
        check_val("wait_no_req", 32'(imem_bus.imem_req), 32'd0);
        check_val("wait_not_halt", 32'(halted), 32'd0);
        n_txn++;
        $display("txn %0d: pc=%02h inst=%03h lat=%0d early=%0d retired=%0d",
                 n_txn, m_inst_pc, m_inst, lat, early_resolve, m_retired);
    endtask

    // Entered in a WAIT cycle; leaves in the cycle after resolve.
    task automatic resolve_one(input int idle, input bit d, input bit a, input logic [7:0] tgt,
                               input bit r, input logic [5:0] off);
        int t;
        for (int i = 0; i < idle; i++) begin
            tick();
            check_val("idle_no_req", 32'(imem_bus.imem_req), 32'd0);
            check_val("idle_inst", 32'(inst), 32'(m_inst));
            check_val("idle_inst_pc", 32'(inst_pc), 32'(m_inst_pc));
        end
        resolve    = 1'b1;
        done       = d;
        take_abs   = a;
        abs_target = tgt;
        take_rel   = r;
        rel_off    = off;
        tick();
        resolve  = 1'b0;
        done     = 1'b0;
        take_abs = 1'b0;
        take_rel = 1'b0;
        if (d) begin
            check_val("halt_flag", 32'(halted), 32'd1);
            check_val("halt_no_req", 32'(imem_bus.imem_req), 32'd0);
        end else begin
            if (a)      t = int'(tgt);
            else if (r) t = m_inst_pc + (int'(off) >= 32 ? int'(off) - 64 : int'(off));
            else        t = m_inst_pc + 1;
            m_pc = ((t % 256) + 256) % 256;
            check_val("next_req", 32'(imem_bus.imem_req), 32'd1);
            check_val("next_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart   = 1'b0;
        m_pc      = 0;
        m_retired = 0;
        check_val("rst_halt_low", 32'(halted), 32'd0);
        check_val("rst_req_low", 32'(imem_bus.imem_req), 32'd0);
        check_val("rst_retired", 32'(retired), 32'd0);
        check_val("rst_addr", 32'(imem_bus.imem_addr), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_inst"}, 32'(inst), 32'd0);
        check_val({tag, "_inst_pc"}, 32'(inst_pc), 32'd0);
        check_val({tag, "_dec"}, 32'(decoder_en), 32'd0);
        check_val({tag, "_req"}, 32'(imem_bus.imem_req), 32'd0);
        check_val({tag, "_addr"}, 32'(imem_bus.imem_addr), 32'd0);
        check_val({tag, "_halted"}, 32'(halted), 32'd0);
        check_val({tag, "_retired"}, 32'(retired), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        bit d, a, rl;

        for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
        mem[0] = 9'h0AB;
        rst_n = 1'b0; start = 1'b0; restart = 1'b0; resolve = 1'b0;
        take_abs = 1'b0; take_rel = 1'b0; abs_target = '0; rel_off = '0; done = 1'b0;
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = '0;
        m_pc = 0; m_retired = 0; m_inst_pc = 0; m_inst = '0;

        #2;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("idle_req", 32'(imem_bus.imem_req), 32'd0);

        // Zero-wait first fetch, then sequential fetches with 3-cycle latency
        do_start();
        fetch_one(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            resolve_one(1, 1'b0, 1'b0, 8'h00, 1'b0, 6'h00);
            fetch_one(3, 1'b0);
        end

        // Relative branches, including wrap past 8'hFF
        resolve_one(0, 1'b0, 1'b1, 8'h05, 1'b0, 6'h00);
        fetch_one(1, 1'b0);
        resolve_one(0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b111101);
        check_val("rel_neg_target", 32'(imem_bus.imem_addr), 32'h02);
        fetch_one(0, 1'b0);
        resolve_one(0, 1'b0, 1'b1, 8'hFE, 1'b0, 6'h00);
        fetch_one(0, 1'b0);
        resolve_one(2, 1'b0, 1'b0, 8'h00, 1'b1, 6'd4);
        check_val("rel_wrap_target", 32'(imem_bus.imem_addr), 32'h02);
        fetch_one(0, 1'b0);
        resolve_one(0, 1'b0, 1'b1, 8'h40, 1'b1, 6'd7);
        check_val("abs_target", 32'(imem_bus.imem_addr), 32'h40);
        fetch_one(2, 1'b0);

        // done beats take_abs; start cannot leave HALT
        resolve_one(0, 1'b1, 1'b1, 8'h09, 1'b0, 6'h00);
        for (int i = 0; i < 3; i++) begin
            do_start();
            check_val("halt_sticky", 32'(halted), 32'd1);
            check_val("halt_sticky_req", 32'(imem_bus.imem_req), 32'd0);
        end
        do_restart();

        // Restart mid-FETCH drops the late memory response
        do_start();
        fetch_one(0, 1'b0);
        resolve_one(0, 1'b0, 1'b1, 8'h33, 1'b0, 6'h00);
        tick();
        do_restart();
        imem_bus.imem_valid = 1'b1;
        tick();
        imem_bus.imem_valid = 1'b0;
        check_val("late_valid_no_dec", 32'(decoder_en), 32'd0);
        tick();
        check_val("late_valid_no_dec2", 32'(decoder_en), 32'd0);
        check_val("late_valid_idle", 32'(imem_bus.imem_req), 32'd0);
        check_val("late_valid_retired", 32'(retired), 32'd0);

        // Randomized traffic
        do_start();
        for (int n = 0; n < 80; n++) begin
            fetch_one(int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
            r  = int'($urandom_range(0, 11));
            d  = (r == 0);
            a  = ($urandom_range(0, 2) == 0);
            rl = 1'($urandom);
            resolve_one(int'($urandom_range(0, 2)), d, a, 8'($urandom), rl, 6'($urandom));
            if (d) begin
                tick();
                check_val("rand_halted", 32'(halted), 32'd1);
                do_restart();
                do_start();
            end
        end

        // Async reset in the decoder_en cycle takes effect before any edge
        do_restart();
        do_start();
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = 9'h1C3;
        tick();
        imem_bus.imem_valid = 1'b0;
        check_val("pre_areset_dec", 32'(decoder_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("areset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
